posit_stream_decoder: RTL and testbench

//  Multi-cycle posit<NBITS,ES> decoder with valid/ready handshakes on both sides. It is the inverse of the

---
 rtl/posit_stream_decoder.sv | 196 +++++++++++++++++++
 tb/tb_posit_stream_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : posit_stream_decoder
// Brief    : Multi-cycle posit<NBITS,ES> field decoder with valid/ready on both
//            sides. POSIT_DEC_FASTSCAN_EN selects a single-cycle regime scan.
// Revision : 1.0  initial release
// ============================================================================
module posit_stream_decoder #(
    parameter int NBITS  = 16,
    parameter int ES     = 1,
    parameter int EXP_W  = 6,
    parameter int FRAC_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [NBITS-1:0]  io_in_data,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic              io_out_sign,
    output logic [EXP_W-1:0]  io_out_exponent,
    output logic [FRAC_W-1:0] io_out_fraction,
    output logic              io_out_isZero,
    output logic              io_out_isNaR
);

    localparam int C_BODY_W = NBITS - 1;
    localparam int C_K_W    = $clog2(NBITS);
    localparam int C_FBITS  = FRAC_W - 1;

    localparam logic [NBITS-1:0]    C_NAR      = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [C_BODY_W-1:0] C_BODY_ONE = C_BODY_W'(1);
    localparam logic [C_K_W-1:0]    C_K_ONE    = C_K_W'(1);
    localparam logic [EXP_W-1:0]    C_EXP_ONE  = EXP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_ASSEMBLE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t              r_state;
    logic [C_BODY_W-1:0] r_shift;
    logic [C_K_W-1:0]    r_kCount;
    logic                r_polarity;
    logic                r_sign;

    logic                r_outValid;
    logic                r_outSign;
    logic [EXP_W-1:0]    r_outExponent;
    logic [FRAC_W-1:0]   r_outFraction;
    logic                r_outIsZero;
    logic                r_outIsNaR;

    logic [C_BODY_W-1:0]         w_absBody;
    logic                        w_isZero;
    logic                        w_isNaR;
    logic [C_BODY_W-1:0]         w_rem;
    logic [EXP_W-1:0]            w_eExt;
    logic [C_BODY_W-1:0]         w_fracSrc;
    logic [C_BODY_W+C_FBITS-1:0] w_fracWide;
    logic [C_FBITS-1:0]          w_fracBits;
    logic [EXP_W-1:0]            w_kExt;
    logic [EXP_W-1:0]            w_regime;
    logic [EXP_W-1:0]            w_exponent;

    // Low NBITS-1 bits of the two's-complement negation depend only on the low bits.
    assign w_absBody = io_in_data[NBITS-1] ? (~io_in_data[NBITS-2:0] + C_BODY_ONE)
                                           : io_in_data[NBITS-2:0];
    assign w_isZero  = (io_in_data == '0);
    assign w_isNaR   = (io_in_data == C_NAR);

    // After the scan, r_shift holds the terminator (if any) at its MSB; zeros
    // shift in behind, so missing exponent and fraction bits read as 0.
    assign w_rem      = r_shift << 1;
    assign w_eExt     = EXP_W'(w_rem >> (C_BODY_W - ES));
    assign w_fracSrc  = w_rem << ES;
    assign w_fracWide = {w_fracSrc, {C_FBITS{1'b0}}};
    assign w_fracBits = w_fracWide[C_BODY_W+C_FBITS-1 -: C_FBITS];

    assign w_kExt     = EXP_W'(r_kCount);
    assign w_regime   = r_polarity ? (w_kExt - C_EXP_ONE) : (-w_kExt);
    assign w_exponent = (w_regime << ES) + w_eExt;

`ifdef POSIT_DEC_FASTSCAN_EN
    logic [C_K_W-1:0] w_fastK;
    logic             w_runOpen;

    // Leading-run length of bits equal to the regime polarity.
    always_comb begin
        w_fastK   = '0;
        w_runOpen = 1'b1;
        for (int i = C_BODY_W - 1; i >= 0; i--) begin
            if (w_runOpen && (r_shift[i] == r_polarity)) begin
                w_fastK = w_fastK + C_K_ONE;
            end else begin
                w_runOpen = 1'b0;
            end
        end
    end
`else
    localparam logic [C_K_W-1:0] C_K_MAX = C_K_W'(C_BODY_W);

    logic             w_nextBit;
    logic [C_K_W-1:0] w_kInc;

    assign w_nextBit = r_shift[C_BODY_W-2];
    assign w_kInc    = r_kCount + C_K_ONE;
`endif

    assign io_in_ready     = (r_state == ST_IDLE) & reset;
    assign io_out_valid    = r_outValid;
    assign io_out_sign     = r_outSign;
    assign io_out_exponent = r_outExponent;
    assign io_out_fraction = r_outFraction;
    assign io_out_isZero   = r_outIsZero;
    assign io_out_isNaR    = r_outIsNaR;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_kCount      <= '0;
            r_polarity    <= 1'b0;
            r_sign        <= 1'b0;
            r_outValid    <= 1'b0;
            r_outSign     <= 1'b0;
            r_outExponent <= '0;
            r_outFraction <= '0;
            r_outIsZero   <= 1'b0;
            r_outIsNaR    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_in_valid) begin
                        r_sign     <= io_in_data[NBITS-1];
                        r_shift    <= w_absBody;
                        r_polarity <= w_absBody[C_BODY_W-1];
                        r_kCount   <= '0;
                        if (w_isZero || w_isNaR) begin
                            r_outValid    <= 1'b1;
                            r_outSign     <= 1'b0;
                            r_outExponent <= '0;
                            r_outFraction <= '0;
                            r_outIsZero   <= w_isZero;
                            r_outIsNaR    <= w_isNaR;
                            r_state       <= ST_DONE;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                end

                ST_SCAN: begin
`ifdef POSIT_DEC_FASTSCAN_EN
                    r_kCount <= w_fastK;
                    r_shift  <= r_shift << w_fastK;
                    r_state  <= ST_ASSEMBLE;
`else
                    // The MSB always matches polarity; stop when the next bit differs or the body is used up.
                    r_kCount <= w_kInc;
                    r_shift  <= r_shift << 1;
                    if ((w_nextBit != r_polarity) || (w_kInc == C_K_MAX)) begin
                        r_state <= ST_ASSEMBLE;
                    end
`endif
                end

                ST_ASSEMBLE: begin
                    r_outValid    <= 1'b1;
                    r_outSign     <= r_sign;
                    r_outExponent <= w_exponent;
                    r_outFraction <= {1'b1, w_fracBits};
                    r_outIsZero   <= 1'b0;
                    r_outIsNaR    <= 1'b0;
                    r_state       <= ST_DONE;
                end

                ST_DONE: begin
                    if (io_out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_stream_decoder
// Brief    : Directed self-checking bench for posit_stream_decoder<16,1>.
// Revision : 1.0  initial release
// ============================================================================
module tb_posit_stream_decoder;

`ifdef POSIT_DEC_FASTSCAN_EN
    localparam bit C_FAST = 1'b1;
`else
    localparam bit C_FAST = 1'b0;
`endif
    localparam int C_TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic [15:0] inData = '0;
    logic        outReady = 1'b0;
    logic        inReady;
    logic        outValid;
    logic        outSign;
    logic [5:0]  outExponent;
    logic [13:0] outFraction;
    logic        outIsZero;
    logic        outIsNaR;

    int total = 0;
    int bad   = 0;

    posit_stream_decoder #(
        .NBITS  (16),
        .ES     (1),
        .EXP_W  (6),
        .FRAC_W (14)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (inValid),
        .io_in_ready     (inReady),
        .io_in_data      (inData),
        .io_out_valid    (outValid),
        .io_out_ready    (outReady),
        .io_out_sign     (outSign),
        .io_out_exponent (outExponent),
        .io_out_fraction (outFraction),
        .io_out_isZero   (outIsZero),
        .io_out_isNaR    (outIsNaR)
    );

    always #5 clock = ~clock;

    // Presents one input and returns the latency (negedges after the handshake
    // edge) plus the output fields sampled when out_valid first rises.
    task automatic run_decode(input logic [15:0] d, output int lat,
                              output logic [20:0] fields, output logic [1:0] flags);
        @(negedge clock);
        inValid = 1'b1;
        inData  = d;
        @(negedge clock);
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < C_TIMEOUT) begin
            @(negedge clock);
            lat++;
        end
        fields = {outSign, outExponent, outFraction};
        flags  = {outIsZero, outIsNaR};
    endtask

    task automatic accept_result();
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({inReady, outValid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold: ready/valid=%b required 00", {inReady, outValid});
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({inReady, outValid, outSign, outExponent, outFraction, outIsZero, outIsNaR} !== {1'b1, 24'h0}) begin
            bad++;
            $display("FAIL reset_state: ready=%b valid=%b s=%b e=%h f=%h z=%b n=%b required ready=1 rest 0",
                     inReady, outValid, outSign, outExponent, outFraction, outIsZero, outIsNaR);
        end
    endtask

    task automatic test_basic_decode();
        logic [15:0] vIn  [8];
        logic [20:0] vExp [8];
        int          vLat [8];
        int          lat;
        logic [20:0] fields;
        logic [1:0]  flags;
        vIn  = '{16'h4000, 16'h4800, 16'h5000, 16'hC000, 16'h6000, 16'h3000, 16'hB800, 16'h4001};
        vExp = '{{1'b0, 6'h00, 14'h2000}, {1'b0, 6'h00, 14'h3000}, {1'b0, 6'h01, 14'h2000},
                 {1'b1, 6'h00, 14'h2000}, {1'b0, 6'h02, 14'h2000}, {1'b0, 6'h3F, 14'h2000},
                 {1'b1, 6'h00, 14'h3000}, {1'b0, 6'h00, 14'h2002}};
        vLat = '{3, 3, 3, 3, 4, 3, 3, 3};
        for (int i = 0; i < 8; i++) begin
            run_decode(vIn[i], lat, fields, flags);
            total++;
            if (lat !== (C_FAST ? 3 : vLat[i])) begin
                bad++;
                $display("FAIL basic_latency in=%h: got %0d required %0d", vIn[i], lat, C_FAST ? 3 : vLat[i]);
            end
            total++;
            if ({fields, flags} !== {vExp[i], 2'b00}) begin
                bad++;
                $display("FAIL basic_fields in=%h: got s/e/f=%h flags=%b required %h flags=00",
                         vIn[i], fields, flags, vExp[i]);
            end
            accept_result();
        end
    endtask

    task automatic test_special();
        int          lat;
        logic [20:0] fields;
        logic [1:0]  flags;
        run_decode(16'h0000, lat, fields, flags);
        total++;
        if ({lat[7:0], fields, flags} !== {8'd1, 21'h0, 2'b10}) begin
            bad++;
            $display("FAIL zero: lat=%0d fields=%h flags=%b required lat=1 fields=0 flags=10", lat, fields, flags);
        end
        accept_result();
        run_decode(16'h8000, lat, fields, flags);
        total++;
        if ({lat[7:0], fields, flags} !== {8'd1, 21'h0, 2'b01}) begin
            bad++;
            $display("FAIL nar: lat=%0d fields=%h flags=%b required lat=1 fields=0 flags=01", lat, fields, flags);
        end
        accept_result();
    endtask

    task automatic test_extremes();
        int          lat;
        logic [20:0] fields;
        logic [1:0]  flags;
        run_decode(16'h7FFF, lat, fields, flags);
        total++;
        if (lat !== (C_FAST ? 3 : 17) || {fields, flags} !== {1'b0, 6'd28, 14'h2000, 2'b00}) begin
            bad++;
            $display("FAIL maxpos: lat=%0d fields=%h flags=%b required lat=%0d fields=%h", lat, fields, flags,
                     C_FAST ? 3 : 17, {1'b0, 6'd28, 14'h2000});
        end
        accept_result();
        run_decode(16'h0001, lat, fields, flags);
        total++;
        if (lat !== (C_FAST ? 3 : 16) || {fields, flags} !== {1'b0, 6'h24, 14'h2000, 2'b00}) begin
            bad++;
            $display("FAIL minpos: lat=%0d fields=%h flags=%b required lat=%0d fields=%h", lat, fields, flags,
                     C_FAST ? 3 : 16, {1'b0, 6'h24, 14'h2000});
        end
        accept_result();
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [20:0] fields;
        logic [1:0]  flags;
        run_decode(16'h5000, lat, fields, flags);
        inValid = 1'b1;
        inData  = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            total++;
            if ({outValid, inReady, outSign, outExponent, outFraction, outIsZero, outIsNaR}
                    !== {2'b10, 1'b0, 6'h01, 14'h2000, 2'b00}) begin
                bad++;
                $display("FAIL backpressure_hold cyc=%0d: valid=%b ready=%b e=%h f=%h z=%b n=%b required valid=1 ready=0 e=01 f=2000",
                         i, outValid, inReady, outExponent, outFraction, outIsZero, outIsNaR);
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
        total++;
        if ({inReady, outValid} !== 2'b10) begin
            bad++;
            $display("FAIL backpressure_release: ready/valid=%b required 10", {inReady, outValid});
        end
    endtask

    task automatic test_reset_mid_scan();
        int          lat;
        logic [20:0] fields;
        logic [1:0]  flags;
        int          strayValid;
        @(negedge clock);
        inValid = 1'b1;
        inData  = 16'h7FFF;
        @(negedge clock);
        inValid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({outValid, inReady, outExponent, outFraction} !== {2'b00, 20'h0}) begin
            bad++;
            $display("FAIL midscan_reset: valid=%b ready=%b e=%h f=%h required all 0",
                     outValid, inReady, outExponent, outFraction);
        end
        reset = 1'b1;
        #1;
        total++;
        if (inReady !== 1'b1) begin
            bad++;
            $display("FAIL midscan_release_ready: got %b required 1", inReady);
        end
        strayValid = 0;
        repeat (20) begin
            @(negedge clock);
            if (outValid) strayValid++;
        end
        total++;
        if (strayValid != 0) begin
            bad++;
            $display("FAIL midscan_discard: out_valid high on %0d cycles required 0", strayValid);
        end
        run_decode(16'h4000, lat, fields, flags);
        total++;
        if (lat !== 3 || {fields, flags} !== {1'b0, 6'h00, 14'h2000, 2'b00}) begin
            bad++;
            $display("FAIL midscan_fresh: lat=%0d fields=%h flags=%b required lat=3 fields=%h",
                     lat, fields, flags, {1'b0, 6'h00, 14'h2000});
        end
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_special();
        test_extremes();
        test_backpressure();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
